dram_fifo_reader: RTL

- Read-side controller for a dual-port distributed-RAM buffer (DATA_WIDTH x 2^DATA_DEPTH). The buffer is written by an independent writer on the same clock.
- Drives the buffer's read address, registers the asynchronous read data into an output stage, and presents it on a valid/ready stream.
- Returns its read pointer to the writer for full detection. Used wherever a producer fills a small distributed-RAM ring and a consumer drains it with backpressure.

---
 rtl/dram_fifo_reader.sv | 65 ++++++
 1 files changed

// File: rtl/dram_fifo_reader.sv
// Read side of a distributed-RAM ring buffer: drives the RAM read address,
// registers the asynchronous read data and presents it on a valid/ready stream.
module dram_fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_DEPTH:0]   wr_ptr,
    output logic [DATA_DEPTH-1:0] ram_ar,
    input  logic [DATA_WIDTH-1:0] ram_qr,
    output logic [DATA_DEPTH:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    input  logic                  flush,
    output logic                  empty,
    output logic [DATA_DEPTH+1:0] level,
    output logic                  overrun
);

    // A full ring holds exactly 2^DATA_DEPTH words; anything above means the writer overran.
    localparam logic [DATA_DEPTH:0] CAPACITY = {1'b1, {DATA_DEPTH{1'b0}}};

    logic [DATA_DEPTH:0] avail;
    logic                load;
    logic                unload;

    // Stream handshake: a word moves on any posedge where dout_valid && dout_ready;
    // dout and dout_valid are registers only, so dout_ready never reaches them combinationally.
    always_comb begin
        avail  = wr_ptr - rd_ptr;
        load   = (avail != '0) && (!dout_valid || dout_ready) && !flush;
        unload = dout_valid && dout_ready;
    end

    assign ram_ar = rd_ptr[DATA_DEPTH-1:0];
    assign empty  = (avail == '0) && !dout_valid;
    assign level  = {1'b0, avail} + {{(DATA_DEPTH+1){1'b0}}, dout_valid};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (avail > CAPACITY) begin
                overrun <= 1'b1;
            end
            // flush jumps to the writer's pre-edge pointer, so a word written this cycle survives
            if (flush) begin
                rd_ptr     <= wr_ptr;
                dout_valid <= 1'b0;
            end else if (load) begin
                dout       <= ram_qr;
                dout_valid <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
            end else if (unload) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule
